// File: rtl/dpram_be_pkg.sv
// Shared definitions for the byte-lane dual-port RAM.
// Contents: FSM state encoding, lane-count helper and the width
// compatibility check used at elaboration by dpram_be.
package dpram_be_pkg;

  typedef enum logic [0:0] {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } dpram_st_e;

  // Number of write lanes in a DW-bit word split into SW-bit lanes.
  function automatic int unsigned lane_count(input int unsigned dw, input int unsigned sw);
    return dw / sw;
  endfunction

  // True when DW splits into a whole number of lanes.
  function automatic bit lanes_ok(input int unsigned dw, input int unsigned sw);
    return (sw != 0) && ((dw % sw) == 0);
  endfunction

endpackage

// File: rtl/dpram_clr_seq.sv
// Post-reset clear sequencer for dpram_be.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset, restarts the clear
//   o_clr_adr  address being zeroed this cycle
//   o_clr_we   high while the clear is in progress
//   o_rdy      high once every word has been zeroed
module dpram_clr_seq
  import dpram_be_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [AW-1:0] o_clr_adr,
  output logic          o_clr_we,
  output logic          o_rdy
);

  dpram_st_e     r_state;
  dpram_st_e     w_state_nxt;
  logic [AW-1:0] r_cnt;

  // State register and clear counter; the clear ignores ena_i.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_CLR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLR) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Leave CLR on the edge that zeroes the last word; RUN is terminal.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_CLR) && (r_cnt == '1)) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_comb begin
    o_clr_we  = (r_state == ST_CLR);
    o_clr_adr = r_cnt;
    o_rdy     = (r_state == ST_RUN);
  end

endmodule

// File: rtl/dpram_be.sv
// Dual-port distributed RAM with byte-lane writes and hardware clear.
// Ports:
//   clk_i   clock             rst_i   sync active-high reset
//   ena_i   global enable     rdy_o   clear finished
//   adr_i   port A address    dat_i   port A write data
//   wre_i   port A write      sel_i   port A lane enables
//   dat_o   port A read data
//   xadr_i  port X address    xdat_o  port X read data
// REG=0 gives combinational reads, REG=1 registered write-first reads
// with A-to-X bypass.
module dpram_be
  import dpram_be_pkg::*;
#(
  parameter int unsigned AW  = 5,
  parameter int unsigned DW  = 32,
  parameter int unsigned SW  = 8,
  parameter int unsigned REG = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ena_i,
  input  logic [AW-1:0]                adr_i,
  input  logic [DW-1:0]                dat_i,
  input  logic                         wre_i,
  input  logic [lane_count(DW, SW)-1:0] sel_i,
  output logic [DW-1:0]                dat_o,
  input  logic [AW-1:0]                xadr_i,
  output logic [DW-1:0]                xdat_o,
  output logic                         rdy_o
);

  localparam int unsigned SL    = lane_count(DW, SW);
  localparam int unsigned Depth = 2 ** AW;

  if (!lanes_ok(DW, SW)) begin : g_bad_lanes
    $error("dpram_be: DW must be a multiple of SW");
  end

  logic [DW-1:0] r_ram [Depth];

  logic [AW-1:0] w_clr_adr;
  logic          w_clr_we;
  logic          w_rdy;
  logic          w_wr;
  logic [DW-1:0] w_rd_a;
  logic [DW-1:0] w_rd_x;
  logic [DW-1:0] w_merged;
  logic [AW-1:0] w_wadr;
  logic [DW-1:0] w_wdat;
  logic          w_we;

  dpram_clr_seq #(
    .AW (AW)
  ) u_clr_seq (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .o_clr_adr (w_clr_adr),
    .o_clr_we  (w_clr_we),
    .o_rdy     (w_rdy)
  );

  assign w_wr   = w_rdy & ena_i & wre_i;
  assign w_rd_a = r_ram[adr_i];
  assign w_rd_x = r_ram[xadr_i];

  // Post-write word: selected lanes from dat_i, the rest from the array.
  always_comb begin
    w_merged = w_rd_a;
    for (int k = 0; k < SL; k++) begin
      if (sel_i[k]) begin
        w_merged[k*SW +: SW] = dat_i[k*SW +: SW];
      end
    end
  end

  // Single write port shared by the clear sequencer and port A.
  always_comb begin
    w_wadr = w_clr_we ? w_clr_adr : adr_i;
    w_wdat = w_clr_we ? '0 : w_merged;
    w_we   = ~rst_i & (w_clr_we | w_wr);
  end

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_ram[w_wadr] <= w_wdat;
    end
  end

  assign rdy_o = w_rdy;

  if (REG != 0) begin : g_reg
    logic [DW-1:0] r_dat;
    logic [DW-1:0] r_xdat;

    // Loading zero while clearing keeps stale pre-clear words from
    // surfacing once rdy_o rises.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_dat  <= '0;
        r_xdat <= '0;
      end else if (ena_i) begin
        if (!w_rdy) begin
          r_dat  <= '0;
          r_xdat <= '0;
        end else begin
          r_dat  <= wre_i ? w_merged : w_rd_a;
          r_xdat <= (wre_i && (xadr_i == adr_i)) ? w_merged : w_rd_x;
        end
      end
    end

    assign dat_o  = w_rdy ? r_dat : '0;
    assign xdat_o = w_rdy ? r_xdat : '0;
  end else begin : g_comb
    assign dat_o  = w_rdy ? w_rd_a : '0;
    assign xdat_o = w_rdy ? w_rd_x : '0;
  end

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: one combinational-read and one registered-read
// instance share the same stimulus.
module tb_dpram_be;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [4:0]  adr;
  logic [31:0] dat;
  logic        wre;
  logic [3:0]  sel;
  logic [4:0]  xadr;
  logic [31:0] c_dat, c_x, r_dat, r_x;
  logic        c_rdy, r_rdy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  adr;
    logic [31:0] dat;
    logic        wre;
    logic [3:0]  sel;
    logic        ena;
    logic [4:0]  xadr;
    logic [31:0] c_dat;  // REG=0, during the cycle (pre-write)
    logic [31:0] c_x;
    logic [31:0] r_dat;  // REG=1, after the edge
    logic [31:0] r_x;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic [31:0] x;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];

  dpram_be #(.AW(5), .DW(32), .SW(8), .REG(0)) u_comb (
    .clk_i  (clk),
    .rst_i  (rst),
    .ena_i  (ena),
    .adr_i  (adr),
    .dat_i  (dat),
    .wre_i  (wre),
    .sel_i  (sel),
    .dat_o  (c_dat),
    .xadr_i (xadr),
    .xdat_o (c_x),
    .rdy_o  (c_rdy)
  );

  dpram_be #(.AW(5), .DW(32), .SW(8), .REG(1)) u_reg (
    .clk_i  (clk),
    .rst_i  (rst),
    .ena_i  (ena),
    .adr_i  (adr),
    .dat_i  (dat),
    .wre_i  (wre),
    .sel_i  (sel),
    .dat_o  (r_dat),
    .xadr_i (xadr),
    .xdat_o (r_x),
    .rdy_o  (r_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; REG=0 checked before the edge, REG=1 after it.
  task automatic step(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    adr  = v.adr;
    dat  = v.dat;
    wre  = v.wre;
    sel  = v.sel;
    ena  = v.ena;
    xadr = v.xadr;
    #1;
    chk({name, " comb dat_o"}, c_dat, v.c_dat);
    chk({name, " comb xdat_o"}, c_x, v.c_x);
    sb.push_back('{dat: v.r_dat, x: v.r_x});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, " reg dat_o"}, r_dat, e.dat);
      chk({name, " reg xdat_o"}, r_x, e.x);
    end
  endtask

  initial begin
    vec_t rd;
    //             adr    dat           wre   sel    ena   xadr   c_dat         c_x           r_dat         r_x
    vecs[0]  = '{5'd3, 32'hAABBCCDD, 1'b1, 4'hF, 1'b1, 5'd3, 32'h0,        32'h0,        32'hAABBCCDD, 32'hAABBCCDD};
    vecs[1]  = '{5'd3, 32'h11223344, 1'b1, 4'h5, 1'b1, 5'd0, 32'hAABBCCDD, 32'h0,        32'hAA22CC44, 32'h0};
    vecs[2]  = '{5'd3, 32'h0,        1'b0, 4'h0, 1'b1, 5'd3, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    vecs[3]  = '{5'd7, 32'h12345678, 1'b1, 4'hF, 1'b1, 5'd7, 32'h0,        32'h0,        32'h12345678, 32'h12345678};
    vecs[4]  = '{5'd7, 32'h12345678, 1'b1, 4'hF, 1'b1, 5'd8, 32'h12345678, 32'h0,        32'h12345678, 32'h0};
    vecs[5]  = '{5'd4, 32'hDEADBEEF, 1'b1, 4'hF, 1'b1, 5'd4, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[6]  = '{5'd4, 32'h0,        1'b0, 4'h0, 1'b1, 5'd3, 32'hDEADBEEF, 32'hAA22CC44, 32'hDEADBEEF, 32'hAA22CC44};
    vecs[7]  = '{5'd2, 32'hFFFFFFFF, 1'b1, 4'hF, 1'b0, 5'd2, 32'h0,        32'h0,        32'hDEADBEEF, 32'hAA22CC44};
    vecs[8]  = '{5'd2, 32'h0,        1'b0, 4'h0, 1'b1, 5'd7, 32'h0,        32'h12345678, 32'h0,        32'h12345678};
    vecs[9]  = '{5'd3, 32'h0,        1'b1, 4'h0, 1'b1, 5'd3, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    vecs[10] = '{5'd5, 32'h55555555, 1'b1, 4'hF, 1'b1, 5'd31, 32'h0,       32'h0,        32'h55555555, 32'h0};

    rst = 1'b1; ena = 1'b0; adr = '0; dat = '0; wre = 1'b0; sel = '0; xadr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset reg dat_o", r_dat, 32'h0);
    chk("reset reg xdat_o", r_x, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Clear lasts exactly 32 cycles.
    for (int i = 0; i < 32; i++) begin
      chk("clear comb rdy_o low", {31'b0, c_rdy}, 32'd0);
      chk("clear reg rdy_o low", {31'b0, r_rdy}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("clear comb rdy_o high", {31'b0, c_rdy}, 32'd1);
    chk("clear reg rdy_o high", {31'b0, r_rdy}, 32'd1);

    // Every word reads zero on both ports.
    for (int a = 0; a < 32; a++) begin
      rd = '{5'(a), 32'h0, 1'b0, 4'h0, 1'b1, 5'(31 - a), 32'h0, 32'h0, 32'h0, 32'h0};
      step(rd, "sweep");
    end

    for (int i = 0; i < 11; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset from RUN, then again mid-clear.
    @(negedge clk);
    rst = 1'b1; wre = 1'b0; ena = 1'b1; adr = 5'd5; xadr = 5'd5;
    @(posedge clk);
    #1;
    chk("rerun reset reg dat_o", r_dat, 32'h0);
    chk("rerun reset comb dat_o", c_dat, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("partial clear comb dat_o masked", c_dat, 32'h0);
      chk("partial clear comb rdy_o", {31'b0, c_rdy}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wre = 1'b1; sel = 4'hF; dat = 32'hAAAA5555;
    for (int i = 0; i < 32; i++) begin
      chk("reclear comb rdy_o low", {31'b0, c_rdy}, 32'd0);
      chk("reclear reg rdy_o low", {31'b0, r_rdy}, 32'd0);
      chk("reclear comb dat_o", c_dat, 32'h0);
      chk("reclear reg dat_o", r_dat, 32'h0);
      @(posedge clk);
      #1;
    end
    chk("reclear comb rdy_o high", {31'b0, c_rdy}, 32'd1);
    chk("reclear reg rdy_o high", {31'b0, r_rdy}, 32'd1);
    rd = '{5'd5, 32'h0, 1'b0, 4'h0, 1'b1, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0};
    step(rd, "dropped write addr5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dpram_be.md
Name: dpram_be

Overview:
- Parametrised successor of the team's two-port distributed RAM: one read/write port (A), one read-only port (X), generic width and depth.
- Adds byte-lane write enables, selectable combinational or registered reads, and write-to-read bypass on X.
- Adds a hardware clear sequencer that zeroes every word after reset, so no simulation-only initialisation is needed.
- Used for register files and small lookup stores in the core pipeline.

Parameters:
- AW, 5, address width; depth = 2**AW.
- DW, 32, data width; must be a multiple of SW.
- SW, 8, lane width; SL = DW/SW lanes.
- REG, 0, read mode: 0 = combinational read (0-cycle latency), 1 = registered read (1-cycle latency).

Ports:
- clk_i  in  1  clock, all state changes on the rising edge
- rst_i  in  1  synchronous reset, active-high
- ena_i  in  1  global clock enable; write and registered-read updates need ena_i=1
- adr_i  in  AW  port A address
- dat_i  in  DW  port A write data
- wre_i  in  1  port A write request
- sel_i  in  SL  port A lane enables, bit k covers dat_i[k*SW +: SW]
- dat_o  out  DW  port A read data
- xadr_i  in  AW  port X address
- xdat_o  out  DW  port X read data
- rdy_o  out  1  high once the clear sequence has finished

Behaviour:
- Two states: CLR and RUN. rst_i=1 at an edge forces CLR, clear counter cnt=0, rdy_o=0, and both registered outputs to 0 (REG=1).
- CLR:
  - Each cycle: rRAM[cnt] <= 0, then cnt <= cnt+1. This is independent of ena_i.
  - When cnt = 2**AW-1 the state moves to RUN, so CLR lasts exactly 2**AW cycles.
  - rdy_o rises on the edge that writes the last word.
- RUN is terminal until the next reset. Reset in either state, including mid-clear, restarts CLR at cnt=0.
- While rdy_o=0:
  - Port A writes are ignored.
  - dat_o and xdat_o are forced to 0 in both REG modes.
- Write (RUN only), when wre_i & ena_i:
  - For each lane k with sel_i[k]=1, the lane is written from dat_i.
  - Unselected lanes keep their old value.
  - sel_i = 0 means no change.
- Merged word W = the post-write value of rRAM[adr_i] (new lanes from dat_i, old lanes from the array).
- REG=0:
  - dat_o = rRAM[adr_i] and xdat_o = rRAM[xadr_i], combinational, showing pre-write contents in the write cycle.
  - ena_i has no effect on reads.
- REG=1, on an edge with ena_i=1:
  - dat_o <= W if writing, else rRAM[adr_i] (write-first).
  - xdat_o <= W if writing and xadr_i == adr_i, else rRAM[xadr_i] (bypass).
  - With ena_i=0 both output registers hold.
- Simultaneous read and write to the same address follows the rules above. There are no illegal input combinations.
- Address wrap: addresses are exactly AW bits; no out-of-range case exists.

Decomposition:
- Shared package holds:
  - state constants ST_CLR, ST_RUN;
  - lane-count function SL = DW/SW;
  - an elaboration check that DW % SW == 0 (error otherwise).
- One natural sub-module, dpram_clr_seq: owns the state, cnt and rdy_o, and drives the clear address and clear enable.
- The top muxes write address and data between dpram_clr_seq (CLR) and port A (RUN).

Test Plan:
- Reset then idle, AW=5: rdy_o=0 for 32 cycles after rst_i drops, 1 from cycle 32 on; every address then reads 0 on both ports.
- REG=1, DW=32, SW=8: write 0xAABBCCDD to address 3 with sel_i=1111, then write 0x11223344 to address 3 with sel_i=0101 -> dat_o = 0xAA22CC44 on the edge after the second write.
- REG=1 bypass: adr_i=xadr_i=7, write 0x12345678 with sel_i=1111 -> xdat_o=0x12345678 one cycle later. Same write with xadr_i=8 -> xdat_o=0.
- REG=0: write 0xDEADBEEF to address 4 -> dat_o shows the old value 0 during the write cycle and 0xDEADBEEF in the next cycle.
- ena_i=0 with wre_i=1 to address 2 -> no change, address 2 still reads 0. REG=1 outputs hold their prior value.
- rst_i pulsed at cycle 10 of a clear, after address 5 had been written before an earlier clear -> rdy_o stays 0 for a full 32 cycles from the new reset, and port A writes during that window are dropped (address 5 reads 0 afterwards).
